seq_chunk_subtractor: RTL and testbench
=======================================

Name: seq_chunk_subtractor

Overview:
- Parametrised multi-cycle subtractor for the ALU subtractor group.
- Computes diff = a - b - bin over WIDTH bits.
- Processes CHUNK bits per clock through a borrow-ripple chunk stage, with a registered borrow between chunks.
- Uses a start/busy/done handshake.
- Trades latency for area on wide datapaths; it is the next generation of the fixed 4-bit ripple borrow subtractor.

Parameters:
- WIDTH, 16, total operand width in bits. Must be ≥ CHUNK and a multiple of CHUNK.
- CHUNK, 4, bits subtracted per clock cycle. Must be ≥ 1.
- NCHUNK, WIDTH/CHUNK, derived localparam. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request. Operands are sampled on the edge where start=1 and the FSM is IDLE or DONE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- diff  output  WIDTH  result. Held stable until the next accepted start.
- bout  output  1  final borrow-out. 1 when a < b + bin (unsigned).
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. It forces:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, bout = 0, zero = 0, ovf = 0
  - chunk index = 0, borrow register = 0
  - operand registers = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch a, b, bin; set idx = 0 and borrow = bin; go to RUN.
  - busy is 1 from the next cycle.
- RUN: each cycle, the chunk stage computes bits [idx*CHUNK +: CHUNK] using the borrow register.
  - Result bits are written into a shadow register.
  - The borrow register takes the chunk borrow-out.
  - idx increments.
  - When idx == NCHUNK-1 is processed, go to DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle.
  - diff, bout, zero and ovf are updated from the shadow register on the RUN→DONE edge. They hold until the next RUN→DONE edge.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted).
- Latency: start sampled at edge E0; done high in the cycle after edge E0+NCHUNK. Throughput is one result per NCHUNK+1 cycles.
- diff does not change during RUN; only the shadow register is written.
- start during RUN is ignored: no queueing, no restart, and operands are not resampled.
- Changes on a, b and bin after acceptance have no effect.
- NCHUNK=1 (WIDTH == CHUNK): RUN lasts one cycle; latency is 2 edges to done.
- Arithmetic:
  - Chunk stage: pure borrow-ripple, d_i = a_i ^ b_i ^ br_i, br_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
  - Wrap-around is modulo 2^WIDTH.
  - bout is the borrow out of the MSB.
- Reset asserted mid-RUN aborts immediately:
  - outputs return to reset values;
  - no done is produced;
  - start in the same cycle as reset is ignored.

Optional Feature:
- Macro: SEQ_SUB_SATURATE_EN.
- Defined: adds an input `sat` (1 bit), sampled together with the operands.
  - With sat=1 and ovf=1, diff is clamped to the signed limit: 2^(WIDTH-1)-1 if a is non-negative, else -2^(WIDTH-1).
  - bout and ovf still report the unclamped result.
  - zero reflects the clamped diff.
- Undefined: the `sat` port is absent and diff is always the wrapped result.

Decomposition:
- Shared package sub_pkg contains:
  - the state enum typedef (IDLE/RUN/DONE);
  - a function computing NCHUNK;
  - a function computing the index width clog2(NCHUNK) with a minimum of 1.
- One natural sub-module: sub_chunk.
  - Parameter W = CHUNK.
  - Combinational ripple-borrow stage with ports a, b, bin, diff, bout.
  - Instantiated once inside seq_chunk_subtractor.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Basic: a=0x1234, b=0x0234, bin=0, start one cycle.
  - busy for 4 cycles, then done pulse.
  - diff=0x1000, bout=0, zero=0, ovf=0.
- Borrow chain across all chunks: a=0x0000, b=0x0001, bin=0.
  - diff=0xFFFF, bout=1, ovf=0.
- Borrow-in and zero: a=0x0005, b=0x0004, bin=1 → diff=0x0000, zero=1, bout=0.
- Signed overflow: a=0x8000, b=0x0001.
  - diff=0x7FFF, ovf=1.
  - With SEQ_SUB_SATURATE_EN and sat=1: diff=0x8000, zero=0.
- Handshake:
  - start re-pulsed and operands changed during RUN → ignored; first result unchanged.
  - start held in the DONE cycle → second op accepted; second done exactly 5 cycles after the first.
- Reset mid-RUN: rst_n=0 at the 2nd RUN cycle.
  - All outputs 0 the next cycle and no done pulse.
  - A new start after release completes normally.
  - Repeat the basic case with WIDTH=8, CHUNK=8: done 2 edges after start.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the chunked sequential subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Number of chunk passes needed to cover the full operand width.
  function automatic int sub_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk build still needs a 1-bit counter.
  function automatic int sub_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational borrow-ripple subtract stage over W bits: diff = a - b - bin.
module sub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  // Ripple the borrow from LSB to MSB, one full-subtractor cell per bit.
  always_comb begin
    logic br;
    br   = bin;
    diff = '0;
    for (int i = 0; i < W; i++) begin
      diff[i] = a[i] ^ b[i] ^ br;
      br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/seq_chunk_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock through a
// single borrow-ripple stage with the borrow carried in a register.
// Optional clamp-on-overflow input 'sat' is enabled by SEQ_SUB_SATURATE_EN.
// WIDTH must be a multiple of CHUNK and CHUNK >= 1.
module seq_chunk_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef SEQ_SUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NCHUNK = sub_nchunk(WIDTH, CHUNK);
  localparam int IW     = sub_idx_w(NCHUNK);
  localparam logic [IW-1:0]    LAST  = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});
  localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};

  sub_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q, shadow_q, diff_q;
  logic [IW-1:0]    idx_q;
  logic             br_q, busy_q, done_q, bout_q, zero_q, ovf_q;
`ifdef SEQ_SUB_SATURATE_EN
  logic             sat_q;
`endif

  logic [CHUNK-1:0] ck_a, ck_b, ck_d;
  logic             ck_bo;
  logic [WIDTH-1:0] shadow_d, res_d;
  logic             ovf_d;
  logic             accept;

  // Operands are only taken when no subtraction is in flight.
  assign accept = start && (state_q != RUN);

  // Select the active chunk of each operand by shifting it down to bit 0.
  always_comb begin
    logic [WIDTH-1:0] a_sh, b_sh;
    int base;
    base = int'(idx_q) * CHUNK;
    a_sh = a_q >> base;
    b_sh = b_q >> base;
    ck_a = a_sh[CHUNK-1:0];
    ck_b = b_sh[CHUNK-1:0];
  end

  sub_chunk #(.W(CHUNK)) u_chunk (
    .a    (ck_a),
    .b    (ck_b),
    .bin  (br_q),
    .diff (ck_d),
    .bout (ck_bo)
  );

  // Merge the current chunk into the shadow and form the final flags; these
  // are only committed on the last chunk.
  always_comb begin
    int base;
    base     = int'(idx_q) * CHUNK;
    shadow_d = (shadow_q & ~(CMASK << base)) | (WIDTH'(ck_d) << base);
    ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (shadow_d[WIDTH-1] != a_q[WIDTH-1]);
    res_d    = shadow_d;
`ifdef SEQ_SUB_SATURATE_EN
    if (sat_q && ovf_d) res_d = a_q[WIDTH-1] ? SMIN : SMAX;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SEQ_SUB_SATURATE_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        a_q     <= a;
        b_q     <= b;
        br_q    <= bin;
        idx_q   <= '0;
        busy_q  <= 1'b1;
`ifdef SEQ_SUB_SATURATE_EN
        sat_q   <= sat;
`endif
      end else begin
        case (state_q)
          RUN: begin
            shadow_q <= shadow_d;
            br_q     <= ck_bo;
            if (idx_q == LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              diff_q  <= res_d;
              bout_q  <= ck_bo;
              zero_q  <= (res_d == '0);
              ovf_q   <= ovf_d;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_subtractor.sv
// Directed self-checking bench: 16/4 main instance plus an 8/8 single-chunk
// instance. Build with SEQ_SUB_SATURATE_EN to also cover the clamp path.
module tb_seq_chunk_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, bin;
  logic [15:0] a, b;
  logic        busy, done, bout, zero, ovf;
  logic [15:0] diff;
`ifdef SEQ_SUB_SATURATE_EN
  logic        sat;
  logic        sat8;
`endif

  logic        start8, bin8;
  logic [7:0]  a8, b8, diff8;
  logic        busy8, done8, bout8, zero8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_chunk_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
`ifdef SEQ_SUB_SATURATE_EN
    .sat(sat),
`endif
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  seq_chunk_subtractor #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
`ifdef SEQ_SUB_SATURATE_EN
    .sat(sat8),
`endif
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
  );

  // Stimulus only: pulse start for one edge (E0) then wait for done.
  // lat = edges after E0 until done is seen (-1 on timeout); bcnt = busy samples.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                       output int lat, output int bcnt);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bcnt = 0;
    for (int n = 0; n <= 20; n++) begin
      if (done) begin lat = n; break; end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
`ifdef SEQ_SUB_SATURATE_EN
    sat = 1'b0; sat8 = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    checks++; if ({busy, done, bout, zero, ovf} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, bout, zero, ovf}); end
    checks++; if (diff !== 16'h0000) begin errors++;
      $display("FAIL reset_diff: got %h want 0000", diff); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    run16(16'h1234, 16'h0234, 1'b0, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL basic_diff: got %h want 1000", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b000) begin errors++;
      $display("FAIL basic_flags: got %b want 000", {bout, zero, ovf}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL basic_diff_hold: got %h want 1000", diff); end
  endtask

  task automatic test_borrow_chain();
    int lat, bc;
    run16(16'h0000, 16'h0001, 1'b0, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL chain_latency: got %0d want 4", lat); end
    checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL chain_diff: got %h want ffff", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b100) begin errors++;
      $display("FAIL chain_flags: got %b want 100", {bout, zero, ovf}); end
    @(posedge clk); #1;
  endtask

  task automatic test_bin_zero();
    int lat, bc;
    run16(16'h0005, 16'h0004, 1'b1, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL binzero_latency: got %0d want 4", lat); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL binzero_diff: got %h want 0000", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b010) begin errors++;
      $display("FAIL binzero_flags: got %b want 010", {bout, zero, ovf}); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat, bc;
    run16(16'h8000, 16'h0001, 1'b0, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency: got %0d want 4", lat); end
    checks++; if (diff !== 16'h7FFF) begin errors++; $display("FAIL ovf_diff: got %h want 7fff", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b001) begin errors++;
      $display("FAIL ovf_flags: got %b want 001", {bout, zero, ovf}); end
    @(posedge clk); #1;
`ifdef SEQ_SUB_SATURATE_EN
    sat = 1'b1;
    run16(16'h8000, 16'h0001, 1'b0, lat, bc);
    sat = 1'b0;
    checks++; if (diff !== 16'h8000) begin errors++; $display("FAIL sat_diff: got %h want 8000", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b001) begin errors++;
      $display("FAIL sat_flags: got %b want 001", {bout, zero, ovf}); end
    @(posedge clk); #1;
    sat = 1'b1;
    run16(16'h7FFF, 16'hFFFF, 1'b0, lat, bc);
    sat = 1'b0;
    checks++; if (diff !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_diff: got %h want 7fff", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b101) begin errors++;
      $display("FAIL sat_pos_flags: got %b want 101", {bout, zero, ovf}); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_ignore_start();
    int lat;
    a = 16'h00FF; b = 16'h000F; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0 accepted
    start = 1'b0;
    @(posedge clk); #1;                       // second RUN cycle
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      if (done) begin lat = n; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ignore_latency: got %0d want 4", lat); end
    checks++; if (diff !== 16'h00F0) begin errors++; $display("FAIL ignore_diff: got %h want 00f0", diff); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++;
      $display("FAIL ignore_no_restart: got %b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    run16(16'h0010, 16'h0001, 1'b0, lat, bc);
    checks++; if (diff !== 16'h000F) begin errors++; $display("FAIL b2b_first_diff: got %h want 000f", diff); end
    a = 16'h0003; b = 16'h0005; bin = 1'b0; start = 1'b1;   // held in the DONE cycle
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin errors++;
      $display("FAIL b2b_accepted: got %b want 10", {busy, done}); end
    checks++; if (diff !== 16'h000F) begin errors++; $display("FAIL b2b_diff_during_run: got %h want 000f", diff); end
    gap = -1;
    for (int n = 1; n <= 20; n++) begin
      if (done) begin gap = n; break; end
      @(posedge clk); #1;
    end
    checks++; if (gap !== 5) begin errors++; $display("FAIL b2b_gap: got %0d want 5", gap); end
    checks++; if (diff !== 16'hFFFE) begin errors++; $display("FAIL b2b_second_diff: got %h want fffe", diff); end
    checks++; if ({bout, zero, ovf} !== 3'b100) begin errors++;
      $display("FAIL b2b_second_flags: got %b want 100", {bout, zero, ovf}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, seen;
    a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0 accepted
    start = 1'b0;
    @(posedge clk); #1;                       // second RUN cycle
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    checks++; if ({busy, done, bout, zero, ovf} !== 5'b0) begin errors++;
      $display("FAIL midrst_flags: got %b want 00000", {busy, done, bout, zero, ovf}); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL midrst_diff: got %h want 0000", diff); end
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen); end
    run16(16'h1234, 16'h0234, 1'b0, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_rerun_latency: got %0d want 4", lat); end
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL midrst_rerun_diff: got %h want 1000", diff); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_chunk();
    int lat;
    a8 = 8'h34; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int n = 0; n <= 10; n++) begin
      if (done8) begin lat = n; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL w8_latency: got %0d want 1", lat); end
    checks++; if (diff8 !== 8'h22) begin errors++; $display("FAIL w8_diff: got %h want 22", diff8); end
    @(posedge clk); #1;
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL w8_done2: got %b want 1", done8); end
    checks++; if ({diff8, bout8, zero8, ovf8} !== {8'hFF, 3'b100}) begin errors++;
      $display("FAIL w8_wrap: got %h/%b want ff/100", diff8, {bout8, zero8, ovf8}); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_chain();
    test_bin_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
